serial_comparator_digit_framed: RTL and testbench

- Parametrised successor to the 1-bit serial comparators. Compares two operands streamed DIGIT_W bits per cycle in frames delimited by first/last flags.
- Digit order (MSB-first or LSB-first) is selectable per frame.
- Provides running comparison outputs per digit, plus a registered end-of-frame result with a valid pulse.
- Sits between serial links and control logic that needs the magnitude relation of multi-digit words.

---
 rtl/serial_comparator_digit_framed.sv | 149 ++++++++++++++
 tb/tb_serial_comparator_digit_framed.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_comparator_digit_framed.sv
// rtl/serial_comparator_digit_framed.sv - framed multi-digit serial magnitude comparator
// Optional signed sign-digit compare is enabled with SERIAL_CMP_SIGNED_EN.
module serial_comparator_digit_framed #(
  parameter int DIGIT_W = 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               in_last,
  input  logic               msb_first,
`ifdef SERIAL_CMP_SIGNED_EN
  input  logic               is_signed,
`endif
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               run_lt,
  output logic               run_eq,
  output logic               run_gt,
  output logic               res_lt,
  output logic               res_eq,
  output logic               res_gt,
  output logic               res_valid,
  output logic [CNT_W-1:0]   dig_cnt,
  output logic               protocol_err
);

  typedef enum logic {S_IDLE, S_IN_FRAME} state_t;
  typedef enum logic [1:0] {REL_EQ = 2'd0, REL_LT = 2'd1, REL_GT = 2'd2} rel_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  rel_t             r_rel;
  rel_t             w_base;
  rel_t             w_d_rel;
  rel_t             w_nrel;
  logic             r_mode;
  logic             w_mode;
  logic             w_accept;
  logic             w_sign_dig;
  logic [2:0]       r_res;
  logic             r_res_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_perr;
  logic             w_perr_nxt;
  logic [2:0]       w_run;

  function automatic logic [2:0] rel_onehot(input rel_t r);
    case (r)
      REL_LT:  rel_onehot = 3'b100;
      REL_GT:  rel_onehot = 3'b001;
      default: rel_onehot = 3'b010;
    endcase
  endfunction

  assign w_accept = in_valid & (in_first | (r_state == S_IN_FRAME));
  assign w_mode   = in_first ? msb_first : r_mode;

`ifdef SERIAL_CMP_SIGNED_EN
  logic r_signed;
  logic w_signed;
  assign w_signed = in_first ? is_signed : r_signed;
  // The sign digit is the most significant one: first when MSB-first, last when LSB-first.
  assign w_sign_dig = w_signed & (w_mode ? in_first : in_last);
`else
  assign w_sign_dig = 1'b0;
`endif

  always_comb begin
    w_d_rel = REL_EQ;
    if (w_sign_dig) begin
      if ($signed(a) > $signed(b))      w_d_rel = REL_GT;
      else if ($signed(a) < $signed(b)) w_d_rel = REL_LT;
    end else begin
      if (a > b)      w_d_rel = REL_GT;
      else if (a < b) w_d_rel = REL_LT;
    end
  end

  // MSB-first: the earliest differing digit decides; LSB-first: the latest one does.
  always_comb begin
    w_base = in_first ? REL_EQ : r_rel;
    w_nrel = w_base;
    if (w_mode) begin
      w_nrel = (w_base == REL_EQ) ? w_d_rel : w_base;
    end else begin
      w_nrel = (w_d_rel == REL_EQ) ? w_base : w_d_rel;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_perr_nxt  = 1'b0;
    w_run       = 3'b000;
    if (in_valid) begin
      if (!in_first && r_state == S_IDLE)      w_perr_nxt = 1'b1;
      if (in_first && r_state == S_IN_FRAME)   w_perr_nxt = 1'b1;
    end
    if (w_accept) begin
      w_run       = rel_onehot(w_nrel);
      w_state_nxt = in_last ? S_IDLE : S_IN_FRAME;
      if (in_first)             w_cnt_nxt = CNT_ONE;
      else if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + CNT_ONE;
    end else if (r_state == S_IN_FRAME) begin
      w_run = rel_onehot(r_rel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rel       <= REL_EQ;
      r_mode      <= 1'b1;
      r_res       <= 3'b000;
      r_res_valid <= 1'b0;
      r_cnt       <= '0;
      r_perr      <= 1'b0;
`ifdef SERIAL_CMP_SIGNED_EN
      r_signed    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_perr      <= w_perr_nxt;
      r_res_valid <= w_accept & in_last;
      r_cnt       <= w_cnt_nxt;
      if (w_accept) begin
        r_rel  <= w_nrel;
        r_mode <= w_mode;
`ifdef SERIAL_CMP_SIGNED_EN
        r_signed <= w_signed;
`endif
        if (in_last) r_res <= rel_onehot(w_nrel);
      end
    end
  end

  assign {run_lt, run_eq, run_gt} = w_run;
  assign {res_lt, res_eq, res_gt} = r_res;
  assign res_valid    = r_res_valid;
  assign dig_cnt      = r_cnt;
  assign protocol_err = r_perr;

endmodule

// File: tb/tb_serial_comparator_digit_framed.sv
// tb/tb_serial_comparator_digit_framed.sv - self-checking bench for serial_comparator_digit_framed
// Directed vector table, hand sequences and random frames against a value-based model.
module tb_serial_comparator_digit_framed;

  localparam int DW = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_first, in_last, msb_first;
  logic          is_signed;
  logic [DW-1:0] a, b;
  logic          run_lt, run_eq, run_gt;
  logic          res_lt, res_eq, res_gt;
  logic          res_valid;
  logic [CW-1:0] dig_cnt;
  logic          protocol_err;

  int n_chk = 0;
  int n_err = 0;

  serial_comparator_digit_framed #(.DIGIT_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_first     (in_first),
    .in_last      (in_last),
    .msb_first    (msb_first),
`ifdef SERIAL_CMP_SIGNED_EN
    .is_signed    (is_signed),
`endif
    .a            (a),
    .b            (b),
    .run_lt       (run_lt),
    .run_eq       (run_eq),
    .run_gt       (run_gt),
    .res_lt       (res_lt),
    .res_eq       (res_eq),
    .res_gt       (res_gt),
    .res_valid    (res_valid),
    .dig_cnt      (dig_cnt),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model: relation of the whole numbers seen so far
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  bit            m_in, m_mode, m_sgn, m_rv, m_perr;
  logic [2:0]    m_rel, m_res;
  int            m_cnt;

  function automatic logic [2:0] model_rel(input bit last_now);
    longint va = 0;
    longint vb = 0;
    int     k  = qa.size();
    int     nb = k * DW;
    for (int i = 0; i < k; i++) begin
      if (m_mode) begin
        va = (va << DW) | longint'(qa[i]);
        vb = (vb << DW) | longint'(qb[i]);
      end else begin
        va = va | (longint'(qa[i]) << (DW * i));
        vb = vb | (longint'(qb[i]) << (DW * i));
      end
    end
    if (m_sgn && (m_mode || last_now) && nb < 63) begin
      if (va[nb-1]) va = va - (longint'(1) << nb);
      if (vb[nb-1]) vb = vb - (longint'(1) << nb);
    end
    if (va < vb) return 3'b100;
    if (va > vb) return 3'b001;
    return 3'b010;
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete();
    m_in = 0; m_mode = 1; m_sgn = 0; m_rv = 0; m_perr = 0;
    m_rel = 3'b010; m_res = 3'b000; m_cnt = 0;
  endtask

  task automatic model_step(input bit v, f, l, m, s, input logic [DW-1:0] av, bv,
                            output logic [2:0] er);
    bit acc;
    acc    = v && (f || m_in);
    er     = 3'b000;
    m_perr = v && (f ? m_in : !m_in);
    m_rv   = 0;
    if (acc) begin
      if (f) begin
        qa.delete(); qb.delete();
        m_mode = m;
`ifdef SERIAL_CMP_SIGNED_EN
        m_sgn  = s;
`else
        m_sgn  = 0;
`endif
        m_cnt  = 1;
      end else if (m_cnt < (1 << CW) - 1) begin
        m_cnt++;
      end
      qa.push_back(av); qb.push_back(bv);
      m_rel = model_rel(l);
      er    = m_rel;
      if (l) begin
        m_res = m_rel; m_rv = 1; m_in = 0;
      end else begin
        m_in = 1;
      end
    end else if (m_in) begin
      er = m_rel;
    end
  endtask

  task automatic cyc(input bit v, f, l, m, input logic [DW-1:0] av, bv, input bit s);
    logic [2:0] er;
    in_valid = v; in_first = f; in_last = l; msb_first = m; a = av; b = bv; is_signed = s;
    model_step(v, f, l, m, s, av, bv, er);
    #1;
    chk("run", {run_lt, run_eq, run_gt}, er);
    @(posedge clk); #1;
    chk("res", {res_lt, res_eq, res_gt}, m_res);
    chk("res_valid", res_valid, m_rv);
    chk("dig_cnt", dig_cnt, m_cnt);
    chk("protocol_err", protocol_err, m_perr);
  endtask

  task automatic do_reset();
    in_valid = 0; in_first = 0; in_last = 0;
    rst_n = 0;
    #1;
    chk("rst_run", {run_lt, run_eq, run_gt}, 3'b000);
    chk("rst_res", {res_lt, res_eq, res_gt}, 3'b000);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_dig_cnt", dig_cnt, 0);
    chk("rst_protocol_err", protocol_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  // ---------------- directed vectors with hand-derived expectations
  typedef struct {
    logic          v, f, l, m;
    logic [DW-1:0] a, b;
    logic [2:0]    run, res;
    logic          rv;
    logic [CW-1:0] cnt;
    logic          perr;
  } vec_t;

  vec_t vecs[20];

  initial begin
    rst_n = 0; in_valid = 0; in_first = 0; in_last = 0; msb_first = 1;
    a = '0; b = '0; is_signed = 0;
    model_reset();

    //           v f l m  a     b     run     res     rv cnt   perr
    vecs[0]  = '{1,1,0,1, 4'h3, 4'h3, 3'b010, 3'b000, 0, 4'd1, 0};
    vecs[1]  = '{1,0,0,1, 4'hA, 4'hA, 3'b010, 3'b000, 0, 4'd2, 0};
    vecs[2]  = '{1,0,1,1, 4'h5, 4'h2, 3'b001, 3'b001, 1, 4'd3, 0};
    vecs[3]  = '{0,0,0,1, 4'h0, 4'h0, 3'b000, 3'b001, 0, 4'd3, 0};
    vecs[4]  = '{1,1,0,0, 4'h1, 4'h2, 3'b100, 3'b001, 0, 4'd1, 0};
    vecs[5]  = '{1,0,1,0, 4'h2, 4'h1, 3'b001, 3'b001, 1, 4'd2, 0};
    vecs[6]  = '{1,1,0,1, 4'h2, 4'h1, 3'b001, 3'b001, 0, 4'd1, 0};
    vecs[7]  = '{1,0,1,1, 4'h1, 4'h2, 3'b001, 3'b001, 1, 4'd2, 0};
    vecs[8]  = '{1,1,1,1, 4'h7, 4'h7, 3'b010, 3'b010, 1, 4'd1, 0};
    vecs[9]  = '{1,1,0,1, 4'h1, 4'h0, 3'b001, 3'b010, 0, 4'd1, 0};
    vecs[10] = '{0,0,0,1, 4'h0, 4'h0, 3'b001, 3'b010, 0, 4'd1, 0};
    vecs[11] = '{1,0,0,0, 4'h0, 4'h9, 3'b001, 3'b010, 0, 4'd2, 0};
    vecs[12] = '{0,0,0,1, 4'h0, 4'h0, 3'b001, 3'b010, 0, 4'd2, 0};
    vecs[13] = '{1,0,1,1, 4'h0, 4'h9, 3'b001, 3'b001, 1, 4'd3, 0};
    vecs[14] = '{1,0,0,1, 4'h5, 4'h1, 3'b000, 3'b001, 0, 4'd3, 1};
    vecs[15] = '{0,0,0,1, 4'h0, 4'h0, 3'b000, 3'b001, 0, 4'd3, 0};
    vecs[16] = '{1,1,0,1, 4'h9, 4'h1, 3'b001, 3'b001, 0, 4'd1, 0};
    vecs[17] = '{1,1,0,1, 4'h2, 4'h3, 3'b100, 3'b001, 0, 4'd1, 1};
    vecs[18] = '{1,0,1,1, 4'h4, 4'h4, 3'b100, 3'b100, 1, 4'd2, 0};
    vecs[19] = '{0,0,0,1, 4'h0, 4'h0, 3'b000, 3'b100, 0, 4'd2, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_run", {run_lt, run_eq, run_gt}, 3'b000);
    chk("reset_res", {res_lt, res_eq, res_gt}, 3'b000);
    chk("reset_res_valid", res_valid, 1'b0);
    chk("reset_dig_cnt", dig_cnt, 0);
    chk("reset_protocol_err", protocol_err, 1'b0);
    rst_n = 1;

    for (int i = 0; i < 20; i++) begin
      in_valid = vecs[i].v; in_first = vecs[i].f; in_last = vecs[i].l;
      msb_first = vecs[i].m; a = vecs[i].a; b = vecs[i].b;
      #1;
      chk($sformatf("vec%0d_run", i), {run_lt, run_eq, run_gt}, vecs[i].run);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_res", i), {res_lt, res_eq, res_gt}, vecs[i].res);
      chk($sformatf("vec%0d_res_valid", i), res_valid, vecs[i].rv);
      chk($sformatf("vec%0d_dig_cnt", i), dig_cnt, vecs[i].cnt);
      chk($sformatf("vec%0d_protocol_err", i), protocol_err, vecs[i].perr);
    end

    // reset after the second digit of a 3-digit frame, then a clean frame
    do_reset();
    cyc(1, 1, 0, 1, 4'h5, 4'h3, 0);
    cyc(1, 0, 0, 1, 4'h2, 4'h2, 0);
    do_reset();
    cyc(0, 0, 0, 1, 4'h0, 4'h0, 0);
    chk("no_res_after_reset", res_valid, 1'b0);
    cyc(1, 1, 0, 0, 4'h8, 4'h2, 0);
    cyc(1, 0, 1, 0, 4'h1, 4'h3, 0);
    chk("clean_frame_lt", {res_lt, res_eq, res_gt}, 3'b100);

    // counter saturation on a long frame of equal digits
    cyc(1, 1, 0, 1, 4'h3, 4'h3, 0);
    for (int i = 0; i < 18; i++) cyc(1, 0, 0, 1, 4'h3, 4'h3, 0);
    cyc(1, 0, 1, 1, 4'h3, 4'h3, 0);
    chk("sat_dig_cnt", dig_cnt, 4'hF);
    chk("sat_res_eq", {res_lt, res_eq, res_gt}, 3'b010);

`ifdef SERIAL_CMP_SIGNED_EN
    cyc(1, 1, 0, 1, 4'hF, 4'h1, 1);
    cyc(1, 0, 1, 1, 4'h0, 4'h0, 1);
    chk("signed_msb_lt", {res_lt, res_eq, res_gt}, 3'b100);
    cyc(1, 1, 0, 1, 4'hF, 4'h1, 0);
    cyc(1, 0, 1, 1, 4'h0, 4'h0, 0);
    chk("unsigned_msb_gt", {res_lt, res_eq, res_gt}, 3'b001);
    cyc(1, 1, 0, 0, 4'h0, 4'h0, 1);
    cyc(1, 0, 1, 0, 4'hF, 4'h1, 1);
    chk("signed_lsb_lt", {res_lt, res_eq, res_gt}, 3'b100);
`endif

    // random traffic, including gaps, framing errors and occasional resets
    for (int n = 0; n < 3000; n++) begin
      bit v, f, l, m, s;
      logic [DW-1:0] av, bv;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        v  = ($urandom_range(0, 9) < 8);
        f  = m_in ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 7);
        l  = (qa.size() >= 11) ? 1'b1 : ($urandom_range(0, 3) == 0);
        m  = $urandom_range(0, 1);
        s  = $urandom_range(0, 1);
        av = $urandom_range(0, 1) ? DW'($urandom_range(0, 15)) : DW'($urandom_range(0, 2));
        bv = $urandom_range(0, 1) ? DW'($urandom_range(0, 15)) : DW'($urandom_range(0, 2));
        cyc(v, f, l, m, av, bv, s);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
